// File: rtl/angle_pkg.sv
// Shared types and helpers for the angle tracker: slot-index width function,
// default angle/period types and the saturated period value.
package angle_pkg;

  localparam int unsigned NB_ANGLES_DEFAULT     = 32'd128;
  localparam int unsigned COUNTER_WIDTH_DEFAULT = 32'd32;

  function automatic int unsigned ANGLE_WIDTH(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

  typedef logic [ANGLE_WIDTH(NB_ANGLES_DEFAULT)-1:0] angle_t;
  typedef logic [COUNTER_WIDTH_DEFAULT-1:0]          period_t;

  localparam period_t PERIOD_MAX = {COUNTER_WIDTH_DEFAULT{1'b1}};

endpackage

// File: rtl/angle_tracker_tick_edge_sync.sv
// Synchroniser for the asynchronous index sensor followed by a falling-edge
// detector; evt is a single-cycle pulse per falling edge of tick.
module tick_edge_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  output logic evt
);

  logic [STAGES-1:0] sync_r;
  logic              last_r;

  // Shift the raw tick through the synchroniser and remember the previous level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {STAGES{1'b0}};
      last_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[STAGES-2:0], tick};
      last_r <= sync_r[STAGES-1];
    end
  end

  assign evt = last_r & ~sync_r[STAGES-1];

endmodule

// File: rtl/angle_tracker.sv
// Angular position estimator: measures the index period and splits each turn
// into NB_ANGLES slots with Bresenham remainder spreading.
// Optional feature macro: ANGLE_TRACKER_OFFSET_EN (per-turn angle offset).
module angle_tracker
  import angle_pkg::*;
#(
  parameter  int unsigned COUNTER_WIDTH = 32,
  parameter  int unsigned NB_ANGLES     = 128,
  parameter  int unsigned SYNC_STAGES   = 2,
  localparam int unsigned AW            = ANGLE_WIDTH(NB_ANGLES),
  localparam int unsigned CW            = COUNTER_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          turn_tick,
  input  logic [AW-1:0] angle_offset,
  output logic [AW-1:0] angle,
  output logic          angle_valid,
  output logic          angle_strobe,
  output logic [CW-1:0] turn_period,
  output logic          stalled
);

  localparam int unsigned   LW        = CW - AW;
  localparam logic [CW-1:0] ONE_C     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] TC_MAX    = {CW{1'b1}};
  localparam logic [CW-1:0] TC_PRE    = TC_MAX - ONE_C;
  localparam logic [AW-1:0] ONE_A     = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] LAST_SLOT = {AW{1'b1}};
  localparam logic [LW:0]   ONE_S     = {{LW{1'b0}}, 1'b1};

  logic          evt;
  logic [CW-1:0] tc_r, tc_s, period_s;
  logic [LW:0]   slot_cnt_r, slot_cnt_s, slot_len_s;
  logic [AW-1:0] err_r, err_s, angle_raw_r, angle_raw_s, angle_s;
  logic [AW:0]   err_sum_s;
  logic          extra_r, extra_s, seen_r, seen_s;
  logic          valid_s, stalled_s, strobe_s, slot_end_s;

  tick_edge_sync #(.STAGES(SYNC_STAGES)) u_tick_edge_sync (
    .clk  (clk),
    .rst  (rst),
    .tick (turn_tick),
    .evt  (evt)
  );

  // Next-state for the period counter, slot sequencer and status flags.
  always_comb begin
    tc_s        = tc_r;
    period_s    = turn_period;
    slot_cnt_s  = slot_cnt_r;
    err_s       = err_r;
    extra_s     = extra_r;
    angle_raw_s = angle_raw_r;
    seen_s      = seen_r;
    valid_s     = angle_valid;
    stalled_s   = stalled;
    slot_len_s  = {1'b0, turn_period[CW-1:AW]} + {{LW{1'b0}}, extra_r};
    slot_end_s  = (slot_cnt_r >= slot_len_s);
    err_sum_s   = {1'b0, err_r} + {1'b0, turn_period[AW-1:0]};
    if (evt) begin
      tc_s        = {CW{1'b0}};
      period_s    = (tc_r == TC_MAX) ? TC_MAX : (tc_r + ONE_C);
      slot_cnt_s  = ONE_S;
      err_s       = {AW{1'b0}};
      extra_s     = 1'b0;
      angle_raw_s = {AW{1'b0}};
      seen_s      = 1'b1;
      valid_s     = seen_r && (period_s[CW-1:AW] != {LW{1'b0}});
      stalled_s   = 1'b0;
    end else begin
      tc_s = (tc_r == TC_MAX) ? TC_MAX : (tc_r + ONE_C);
      // A stall behaves like a fresh start: two more ticks are needed for validity.
      if (tc_r == TC_PRE) begin
        stalled_s = 1'b1;
        valid_s   = 1'b0;
        seen_s    = 1'b0;
      end else begin
        stalled_s = stalled;
      end
      if (slot_end_s) begin
        if (angle_raw_r != LAST_SLOT) begin
          angle_raw_s = angle_raw_r + ONE_A;
          slot_cnt_s  = ONE_S;
          err_s       = err_sum_s[AW-1:0];
          extra_s     = err_sum_s[AW];
        end else begin
          slot_cnt_s = slot_cnt_r;
        end
      end else begin
        slot_cnt_s = slot_cnt_r + ONE_S;
      end
    end
  end

`ifdef ANGLE_TRACKER_OFFSET_EN
  logic [AW-1:0] offset_r, offset_s;

  // Offset is captured only at turn boundaries.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset_r <= {AW{1'b0}};
    end else begin
      offset_r <= offset_s;
    end
  end

  assign offset_s = evt ? angle_offset : offset_r;
  assign angle_s  = angle_raw_s + offset_s;
`else
  logic unused_offset;
  assign unused_offset = ^angle_offset;
  assign angle_s       = angle_raw_s;
`endif

  assign strobe_s = (angle_s != angle) && valid_s;

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tc_r         <= {CW{1'b0}};
      turn_period  <= {CW{1'b0}};
      slot_cnt_r   <= {(LW+1){1'b0}};
      err_r        <= {AW{1'b0}};
      extra_r      <= 1'b0;
      angle_raw_r  <= {AW{1'b0}};
      seen_r       <= 1'b0;
      angle        <= {AW{1'b0}};
      angle_valid  <= 1'b0;
      angle_strobe <= 1'b0;
      stalled      <= 1'b0;
    end else begin
      tc_r         <= tc_s;
      turn_period  <= period_s;
      slot_cnt_r   <= slot_cnt_s;
      err_r        <= err_s;
      extra_r      <= extra_s;
      angle_raw_r  <= angle_raw_s;
      seen_r       <= seen_s;
      angle        <= angle_s;
      angle_valid  <= valid_s;
      angle_strobe <= strobe_s;
      stalled      <= stalled_s;
    end
  end

endmodule
